// File: rtl/serial_comparator_if.sv
// Bus bundle for serial_comparator: request/operands in, busy/done/flags/latency out.
// CMP_SIGNED_EN adds the signed_mode request field.
interface serial_comparator_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
);
  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = $clog2(N + 1);

  logic             start;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
`ifdef CMP_SIGNED_EN
  logic             signed_mode;
`endif
  logic             busy;
  logic             done;
  logic             EQ;
  logic             GTR;
  logic             LR;
  logic [CntW-1:0]  cycles;

  modport master (
    output start, in0, in1,
`ifdef CMP_SIGNED_EN
    output signed_mode,
`endif
    input  busy, done, EQ, GTR, LR, cycles
  );

  modport slave (
    input  start, in0, in1,
`ifdef CMP_SIGNED_EN
    input  signed_mode,
`endif
    output busy, done, EQ, GTR, LR, cycles
  );
endinterface

// File: rtl/serial_comparator.sv
// Digit-serial MSB-first magnitude comparator with early termination and latency report.
// CMP_SIGNED_EN enables two's-complement compare via MSB inversion at latch time.
module serial_comparator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  serial_comparator_if.slave  bus
);
  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CntW = $clog2(N + 1);

  typedef enum logic {StIdle, StCmp} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              eq_q, eq_d;
  logic              gtr_q, gtr_d;
  logic              lr_q, lr_d;
  logic              done_q, done_d;
  logic [CntW-1:0]   cycles_q, cycles_d;
  logic [DIGIT-1:0]  digit_a, digit_b;

  // Operands are shifted left each step so the current digit is always at the top.
  assign digit_a = a_q[WIDTH-1 -: DIGIT];
  assign digit_b = b_q[WIDTH-1 -: DIGIT];

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    eq_d     = eq_q;
    gtr_d    = gtr_q;
    lr_d     = lr_q;
    cycles_d = cycles_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d = bus.in0;
          b_d = bus.in1;
`ifdef CMP_SIGNED_EN
          // Offset-binary: flipping both sign bits makes unsigned order match signed order.
          a_d[WIDTH-1] = bus.in0[WIDTH-1] ^ bus.signed_mode;
          b_d[WIDTH-1] = bus.in1[WIDTH-1] ^ bus.signed_mode;
`endif
          idx_d   = '0;
          state_d = StCmp;
        end
      end
      StCmp: begin
        if (digit_a != digit_b) begin
          eq_d     = 1'b0;
          gtr_d    = digit_a > digit_b;
          lr_d     = digit_a < digit_b;
          cycles_d = CntW'(idx_q) + CntW'(1);
          done_d   = 1'b1;
          state_d  = StIdle;
        end else if (idx_q == IdxW'(N - 1)) begin
          eq_d     = 1'b1;
          gtr_d    = 1'b0;
          lr_d     = 1'b0;
          cycles_d = CntW'(N);
          done_d   = 1'b1;
          state_d  = StIdle;
        end else begin
          idx_d = idx_q + IdxW'(1);
          a_d   = a_q << DIGIT;
          b_d   = b_q << DIGIT;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      eq_q     <= 1'b0;
      gtr_q    <= 1'b0;
      lr_q     <= 1'b0;
      done_q   <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      eq_q     <= eq_d;
      gtr_q    <= gtr_d;
      lr_q     <= lr_d;
      done_q   <= done_d;
      cycles_q <= cycles_d;
    end
  end

  assign bus.busy   = (state_q == StCmp);
  assign bus.done   = done_q;
  assign bus.EQ     = eq_q;
  assign bus.GTR    = gtr_q;
  assign bus.LR     = lr_q;
  assign bus.cycles = cycles_q;
endmodule

// File: tb/tb_serial_comparator.sv
// Scoreboard bench: 8/2 directed+random and 16/4 random sweep against an arithmetic model.
module tb_serial_comparator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit eq;
    bit gtr;
    bit lr;
    int cycles;
    int due;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16, last8, last16;
  int   done8 = 0;

  serial_comparator_if #(.WIDTH(8),  .DIGIT(2)) b8 ();
  serial_comparator_if #(.WIDTH(16), .DIGIT(4)) b16 ();

  serial_comparator #(.WIDTH(8), .DIGIT(2)) u8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8.slave)
  );

  serial_comparator #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b16.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: order from plain integer compare; latency from the top differing bit.
  function automatic exp_t model(input int unsigned a, input int unsigned b,
                                 input int width, input int digit, input bit sm);
    exp_t        e;
    int          hb;
    int unsigned x;
    longint      sa, sb;
    x  = a ^ b;
    hb = -1;
    for (int i = width - 1; i >= 0; i--) if (x[i] && hb < 0) hb = i;
    e.cycles = (hb < 0) ? width / digit : (width - 1 - hb) / digit + 1;
    sa = longint'(a);
    sb = longint'(b);
    if (sm) begin
      if (a[width-1]) sa = sa - (longint'(1) << width);
      if (b[width-1]) sb = sb - (longint'(1) << width);
    end
    e.eq  = (sa == sb);
    e.gtr = (sa > sb);
    e.lr  = (sa < sb);
    e.due = 0;
    return e;
  endfunction

  // Monitors: pop on done, check flags/latency; flags must hold while busy.
  always @(negedge clk) begin
    if (b8.done === 1'b1) begin
      done8++;
      if (q8.size() == 0) chk("u8_unexpected_done", 1, 0);
      else begin
        e8 = q8.pop_front();
        chk("u8_EQ", b8.EQ, e8.eq);
        chk("u8_GTR", b8.GTR, e8.gtr);
        chk("u8_LR", b8.LR, e8.lr);
        chk("u8_cycles", b8.cycles, e8.cycles);
        chk("u8_latency", cyc, e8.due);
        chk("u8_busy_in_done", b8.busy, 0);
        chk("u8_onehot", int'(b8.EQ) + int'(b8.GTR) + int'(b8.LR), 1);
        last8 = e8;
      end
    end else if (b8.busy === 1'b1) begin
      chk("u8_hold_EQ", b8.EQ, last8.eq);
      chk("u8_hold_GTR", b8.GTR, last8.gtr);
      chk("u8_hold_LR", b8.LR, last8.lr);
      chk("u8_hold_cycles", b8.cycles, last8.cycles);
    end
  end

  always @(negedge clk) begin
    if (b16.done === 1'b1) begin
      if (q16.size() == 0) chk("u16_unexpected_done", 1, 0);
      else begin
        e16 = q16.pop_front();
        chk("u16_EQ", b16.EQ, e16.eq);
        chk("u16_GTR", b16.GTR, e16.gtr);
        chk("u16_LR", b16.LR, e16.lr);
        chk("u16_cycles", b16.cycles, e16.cycles);
        chk("u16_latency", cyc, e16.due);
        chk("u16_onehot", int'(b16.EQ) + int'(b16.GTR) + int'(b16.LR), 1);
        last16 = e16;
      end
    end else if (b16.busy === 1'b1) begin
      chk("u16_hold_EQ", b16.EQ, last16.eq);
      chk("u16_hold_GTR", b16.GTR, last16.gtr);
      chk("u16_hold_LR", b16.LR, last16.lr);
      chk("u16_hold_cycles", b16.cycles, last16.cycles);
    end
  end

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic go8(input logic [7:0] a, input logic [7:0] b, input bit sm,
                     input bit b2b, input bit poke);
    int   n;
    exp_t e;
`ifndef CMP_SIGNED_EN
    sm = 1'b0;
`endif
    n = 0;
    while (b8.busy === 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("u8_idle_timeout", 1, 0);
    if (b2b) chk("u8_b2b_in_done_cycle", b8.done, 1);
    e = model(32'(a), 32'(b), 8, 2, sm);
    e.due = cyc + 1 + e.cycles;
    q8.push_back(e);
    b8.start = 1'b1;
    b8.in0   = a;
    b8.in1   = b;
`ifdef CMP_SIGNED_EN
    b8.signed_mode = sm;
`endif
    @(negedge clk);
    b8.start = 1'b0;
    b8.in0   = 8'($urandom);
    b8.in1   = 8'($urandom);
    if (poke && b8.busy === 1'b1) begin
      b8.start = 1'b1;
      @(negedge clk);
      b8.start = 1'b0;
    end
    n = 0;
    while (b8.busy === 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("u8_done_timeout", 1, 0);
  endtask

  task automatic go16(input logic [15:0] a, input logic [15:0] b, input bit sm, input bit poke);
    int   n;
    exp_t e;
`ifndef CMP_SIGNED_EN
    sm = 1'b0;
`endif
    e = model(32'(a), 32'(b), 16, 4, sm);
    e.due = cyc + 1 + e.cycles;
    q16.push_back(e);
    b16.start = 1'b1;
    b16.in0   = a;
    b16.in1   = b;
`ifdef CMP_SIGNED_EN
    b16.signed_mode = sm;
`endif
    @(negedge clk);
    b16.start = 1'b0;
    b16.in0   = 16'($urandom);
    b16.in1   = 16'($urandom);
    if (poke && b16.busy === 1'b1) begin
      b16.start = 1'b1;
      @(negedge clk);
      b16.start = 1'b0;
    end
    n = 0;
    while (b16.busy === 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("u16_done_timeout", 1, 0);
  endtask

  task automatic chk_zero8(input string tag);
    chk({tag, "_busy"}, b8.busy, 0);
    chk({tag, "_done"}, b8.done, 0);
    chk({tag, "_EQ"}, b8.EQ, 0);
    chk({tag, "_GTR"}, b8.GTR, 0);
    chk({tag, "_LR"}, b8.LR, 0);
    chk({tag, "_cycles"}, b8.cycles, 0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    int          d0;
    last8  = '{0, 0, 0, 0, 0};
    last16 = '{0, 0, 0, 0, 0};
    b8.start = 1'b0;  b8.in0 = '0;  b8.in1 = '0;
    b16.start = 1'b0; b16.in0 = '0; b16.in1 = '0;
`ifdef CMP_SIGNED_EN
    b8.signed_mode = 1'b0;
    b16.signed_mode = 1'b0;
`endif
    #1;
    chk_zero8("reset8");
    chk("reset16_busy", b16.busy, 0);
    chk("reset16_flags", {b16.EQ, b16.GTR, b16.LR}, 0);
    chk("reset16_cycles", b16.cycles, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    go8(8'hC3, 8'h43, 1'b0, 1'b0, 1'b0);
    go8(8'h12, 8'h12, 1'b0, 1'b1, 1'b0);
    go8(8'h10, 8'h13, 1'b0, 1'b1, 1'b1);
    go8(8'h01, 8'h02, 1'b0, 1'b1, 1'b1);
`ifdef CMP_SIGNED_EN
    go8(8'h80, 8'h01, 1'b1, 1'b1, 1'b0);
    go8(8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
`endif

    // Abort a compare with reset: outputs clear at once and no done follows.
    @(negedge clk);
    b8.start = 1'b1; b8.in0 = 8'h00; b8.in1 = 8'h00;
    @(negedge clk);
    b8.start = 1'b0;
    @(negedge clk);
    chk("rst_busy_before", b8.busy, 1);
    d0 = done8;
    #2 rst_n = 1'b0;
    #1 chk_zero8("midrst8");
    last8 = '{0, 0, 0, 0, 0};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_no_done", done8, d0);
    go8(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? ra ^ 16'(1 << $urandom_range(0, 7)) : 16'($urandom);
      go8(ra[7:0], rb[7:0], 1'($urandom), 1'b0, 1'($urandom));
    end

    for (int i = 0; i < 150; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ 16'(($urandom_range(1, 15)) << (4 * $urandom_range(0, 3)));
        default: rb = 16'($urandom);
      endcase
      go16(ra, rb, 1'($urandom), 1'($urandom));
    end

    repeat (5) @(negedge clk);
    chk("q8_drained", q8.size(), 0);
    chk("q16_drained", q16.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule
